coherence_req_arbiter: RTL
==========================

Name: coherence_req_arbiter

Overview:
- Sits directly upstream of the directory state machine, between NUM_CACHES cache-block controllers and the directory.
- Serialises cache coherence requests (write miss, read miss, write back) into one transaction at a time and presents each to the directory with a requester ID.
- Routes directory replies (fetch, invalidate, data value reply) back to the correct cache(s) using the directory's sharer vector.

Parameters:
NUM_CACHES, 2, number of cache-block controllers attached
ID_W, 1, requester ID width; must satisfy 2**ID_W >= NUM_CACHES
TIMEOUT, 15, maximum cycles in WAIT before the transaction is abandoned

Ports:
clock  in  1  single clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
req_write_miss  in  NUM_CACHES  per-cache write-miss request, level, held until granted
req_read_miss  in  NUM_CACHES  per-cache read-miss request, level, held until granted
req_write_back  in  NUM_CACHES  per-cache write-back request, level, held until granted
req_grant  out  NUM_CACHES  one-hot, 1-cycle pulse: the cache's request was accepted
dir_write_miss  out  1  1-cycle pulse to directory
dir_read_miss  out  1  1-cycle pulse to directory
dir_write_back  out  1  1-cycle pulse to directory
dir_requester  out  ID_W  ID of current transaction owner; stable from ISSUE until return to IDLE
dir_fetch  in  1  directory fetch request
dir_invalidate  in  1  directory invalidate request
dir_data_reply  in  1  directory data value reply; ends a miss transaction
dir_sharers  in  NUM_CACHES  directory sharer vector
cache_fetch  out  NUM_CACHES  routed fetch, 1-cycle pulse per target
cache_invalidate  out  NUM_CACHES  routed invalidate, 1-cycle pulse per target
cache_data_reply  out  NUM_CACHES  routed data reply, 1-cycle pulse to requester only
busy  out  1  high whenever state is not IDLE
timeout_err  out  1  1-cycle pulse when a WAIT times out
current_state  out  2  FSM state: 00 IDLE, 01 ISSUE, 10 WAIT; 11 never occurs

Behaviour:
- All outputs are registered. Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer 0.
  - Latched ID/type 0.
  - Timeout counter 0.
- Reset wins over every other event. Reset during ISSUE or WAIT abandons the transaction: no grant, reply or error pulse is produced.
- A cache is "requesting" if any of its three req bits is set.
- Intra-cache priority: write_back > write_miss > read_miss. Lower-priority requests stay asserted and compete later.
- Inter-cache arbitration is round-robin:
  - Search starts at the pointer and wraps from NUM_CACHES-1 to 0.
  - After a grant to cache i, the pointer becomes (i+1) mod NUM_CACHES.
- IDLE:
  - Requests are sampled every cycle.
  - If any cache is requesting: latch winner ID and type, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - req_grant[winner]=1.
  - The matching dir_* pulse is 1; dir_requester=winner.
  - Write back: next state is IDLE (directory sends no reply).
  - Miss: next state is WAIT, counter cleared.
  - Request inputs are ignored.
- WAIT:
  - Counter increments each cycle.
  - dir_fetch is routed next cycle: cache_fetch[i] = dir_sharers[i] and i != requester.
  - dir_invalidate is routed the same way to cache_invalidate.
  - dir_data_reply: next cycle cache_data_reply[requester]=1; state goes to IDLE.
  - Fetch, invalidate and data reply arriving in the same cycle are all routed in that same next cycle.
  - If the counter reaches TIMEOUT with no reply: timeout_err pulses, state goes to IDLE, no data reply is produced.
  - A reply arriving in the timeout cycle takes precedence: it is routed, and there is no error.
- dir_fetch, dir_invalidate and dir_data_reply arriving in IDLE or ISSUE are ignored.
- Request held after its grant: the cache drops its request on the edge after seeing req_grant. A request still high when the FSM is back in IDLE is treated as a new request.
- Minimum back-to-back spacing:
  - Write backs: 2 cycles.
  - Misses: 3 cycles plus directory latency.

Test Plan:
- Reset then idle: all outputs 0, current_state=00, busy=0 for 10 cycles.
- Cache 0 read miss; directory replies 3 cycles after the dir_read_miss pulse:
  - req_grant=01 and dir_read_miss=1 with dir_requester=0 in the same cycle.
  - cache_data_reply=01 for one cycle.
  - Back to IDLE.
- Caches 0 and 1 request simultaneously from a reset pointer: cache 0 served first, then cache 1. Repeat with both requesting: cache 1 is not starved and the order alternates.
- Cache 1 asserts write_back and write_miss together: dir_write_back is issued first with no WAIT, then dir_write_miss on the next arbitration.
- During a cache 0 write miss, the directory drives dir_invalidate=1 with dir_sharers=11: cache_invalidate=10, so the requester is excluded.
- Miss with no reply: timeout_err pulses exactly TIMEOUT cycles after entering WAIT, cache_data_reply stays 0, and a reset asserted mid-WAIT in a separate run returns all outputs to 0 next cycle.

Source files
------------

// File: rtl/coherence_req_arbiter.sv
// coherence_req_arbiter
//   Serialises write-miss / read-miss / write-back requests from NUM_CACHES
//   cache-block controllers into one directory transaction at a time. It
//   routes directory fetch / invalidate / data replies back to the caches.
//
// FSM states
//   state | meaning
//   IDLE  | sample requests, pick a round-robin winner
//   ISSUE | one cycle: grant pulse plus dir_* pulse for the latched winner
//   WAIT  | miss outstanding; route directory traffic, watch for timeout
//
// Ports
//   clock, reset                 clock; synchronous active-high reset
//   req_write_miss/read_miss/
//   req_write_back [NUM_CACHES]  level requests, held until granted
//   req_grant      [NUM_CACHES]  one-hot grant pulse (ISSUE cycle)
//   dir_write_miss/read_miss/
//   dir_write_back               request-type pulse to the directory
//   dir_requester  [ID_W]        owner of the current transaction
//   dir_fetch/invalidate/
//   dir_data_reply, dir_sharers  directory replies and sharer vector
//   cache_fetch/invalidate/
//   cache_data_reply             routed reply pulses
//   busy, timeout_err,
//   current_state                status (00 IDLE, 01 ISSUE, 10 WAIT)
module coherence_req_arbiter #(
  parameter int NUM_CACHES = 2,
  parameter int ID_W       = 1,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_CACHES-1:0] req_write_miss,
  input  logic [NUM_CACHES-1:0] req_read_miss,
  input  logic [NUM_CACHES-1:0] req_write_back,
  output logic [NUM_CACHES-1:0] req_grant,
  output logic                  dir_write_miss,
  output logic                  dir_read_miss,
  output logic                  dir_write_back,
  output logic [ID_W-1:0]       dir_requester,
  input  logic                  dir_fetch,
  input  logic                  dir_invalidate,
  input  logic                  dir_data_reply,
  input  logic [NUM_CACHES-1:0] dir_sharers,
  output logic [NUM_CACHES-1:0] cache_fetch,
  output logic [NUM_CACHES-1:0] cache_invalidate,
  output logic [NUM_CACHES-1:0] cache_data_reply,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [1:0]            current_state
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ISSUE = 2'b01;
  localparam logic [1:0] ST_WAIT  = 2'b10;

  localparam logic [1:0] TY_NONE = 2'd0;
  localparam logic [1:0] TY_WB   = 2'd1;
  localparam logic [1:0] TY_WM   = 2'd2;
  localparam logic [1:0] TY_RM   = 2'd3;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Last WAIT cycle: the counter reaches TIMEOUT on the edge that leaves it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]            state;
  logic [ID_W-1:0]       rr_ptr;
  logic [1:0]            type_q;
  logic [CNT_W-1:0]      wait_cnt;

  logic [NUM_CACHES-1:0] requesting;
  logic                  found_hi;
  logic [ID_W-1:0]       id_hi, id_lo, win_id, ptr_next;
  logic [1:0]            cand_type, ty_hi, ty_lo, win_type;
  logic [NUM_CACHES-1:0] win_onehot, owner_onehot;

  // Round robin as two priority scans: the lowest requester at or above the
  // pointer wins; failing that, the lowest requester overall (wrap-around).
  always_comb begin
    requesting = req_write_miss | req_read_miss | req_write_back;
    found_hi   = 1'b0;
    id_hi      = '0;
    id_lo      = '0;
    cand_type  = TY_NONE;
    ty_hi      = TY_NONE;
    ty_lo      = TY_NONE;
    for (int i = NUM_CACHES - 1; i >= 0; i--) begin
      if (req_write_back[i])      cand_type = TY_WB;
      else if (req_write_miss[i]) cand_type = TY_WM;
      else                        cand_type = TY_RM;
      if (requesting[i]) begin
        id_lo = ID_W'(i);
        ty_lo = cand_type;
        if (i >= int'(rr_ptr)) begin
          found_hi = 1'b1;
          id_hi    = ID_W'(i);
          ty_hi    = cand_type;
        end
      end
    end
    win_id   = found_hi ? id_hi : id_lo;
    win_type = found_hi ? ty_hi : ty_lo;
    ptr_next = (int'(win_id) == NUM_CACHES - 1) ? '0 : win_id + ID_W'(1);
    for (int i = 0; i < NUM_CACHES; i++) begin
      win_onehot[i]   = (int'(win_id) == i);
      owner_onehot[i] = (int'(dir_requester) == i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= ST_IDLE;
      rr_ptr           <= '0;
      type_q           <= TY_NONE;
      wait_cnt         <= '0;
      req_grant        <= '0;
      dir_write_miss   <= 1'b0;
      dir_read_miss    <= 1'b0;
      dir_write_back   <= 1'b0;
      dir_requester    <= '0;
      cache_fetch      <= '0;
      cache_invalidate <= '0;
      cache_data_reply <= '0;
      busy             <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      req_grant        <= '0;
      dir_write_miss   <= 1'b0;
      dir_read_miss    <= 1'b0;
      dir_write_back   <= 1'b0;
      cache_fetch      <= '0;
      cache_invalidate <= '0;
      cache_data_reply <= '0;
      timeout_err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|requesting) begin
            state          <= ST_ISSUE;
            busy           <= 1'b1;
            type_q         <= win_type;
            dir_requester  <= win_id;
            rr_ptr         <= ptr_next;
            req_grant      <= win_onehot;
            dir_write_back <= (win_type == TY_WB);
            dir_write_miss <= (win_type == TY_WM);
            dir_read_miss  <= (win_type == TY_RM);
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          // Write backs get no directory reply, so they skip WAIT.
          if (type_q == TY_WB) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dir_fetch)      cache_fetch      <= dir_sharers & ~owner_onehot;
          if (dir_invalidate) cache_invalidate <= dir_sharers & ~owner_onehot;
          // A reply in the final cycle beats the timeout.
          if (dir_data_reply) begin
            cache_data_reply <= owner_onehot;
            state            <= ST_IDLE;
            busy             <= 1'b0;
          end else if (wait_cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
            busy        <= 1'b0;
          end
          wait_cnt <= wait_cnt + CNT_W'(1);
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign current_state = state;

endmodule
